multicycle_fetch_exc_sequencer: RTL and testbench

Parametrised successor to the monolithic control FSM. It owns the fetch/PC+4, decode and dispatch path and precise exception entry; instruction execution is delegated to per-class execute sequencers through an exec_start/exec_done handshake. Memory latency, exception count and the exception vector base are parameters. Adds invalid-opcode, overflow and divide-by-zero trapping, which the previous generation lacked.

---
 rtl/multicycle_fetch_exc_sequencer_pkg.sv | 91 +++++++++
 rtl/multicycle_fetch_exc_sequencer_if.sv | 12 +
 rtl/multicycle_fetch_exc_sequencer_opcode_classifier.sv | 39 +++
 rtl/multicycle_fetch_exc_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_fetch_exc_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_fetch_exc_sequencer_pkg.sv
// rtl/multicycle_fetch_exc_sequencer_pkg.sv - shared encodings for the fetch/dispatch/exception sequencer
package mcpu_ctrl_pkg;

   // Primary opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BLE   = 6'h06;
   localparam logic [5:0] OP_BGT   = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2b;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_MFHI = 6'h10;
   localparam logic [5:0] FN_MFLO = 6'h12;
   localparam logic [5:0] FN_RTE  = 6'h13;
   localparam logic [5:0] FN_MULT = 6'h18;
   localparam logic [5:0] FN_DIV  = 6'h1a;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2a;

   localparam logic [3:0] ALU_NO_OP = 4'd0;
   localparam logic [3:0] ALU_ADD   = 4'd1;
   localparam logic [3:0] ALU_SUB   = 4'd2;
   localparam logic [3:0] ALU_AND   = 4'd3;
   localparam logic [3:0] ALU_OR    = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_NOT   = 4'd6;
   localparam logic [3:0] ALU_SLT   = 4'd7;
   localparam logic [3:0] ALU_LUI   = 4'd8;

   localparam logic [3:0] ST_RESET    = 4'd0;
   localparam logic [3:0] ST_FETCH    = 4'd1;
   localparam logic [3:0] ST_MEM_WAIT = 4'd2;
   localparam logic [3:0] ST_DECODE   = 4'd3;
   localparam logic [3:0] ST_DISPATCH = 4'd4;
   localparam logic [3:0] ST_EXEC     = 4'd5;
   localparam logic [3:0] ST_EXC_EPC  = 4'd6;
   localparam logic [3:0] ST_EXC_READ = 4'd7;
   localparam logic [3:0] ST_EXC_LOAD = 4'd8;
   localparam logic [3:0] ST_EXC_JUMP = 4'd9;

   typedef enum logic [2:0] {
      CLS_R_ALU     = 3'd0,
      CLS_R_SHIFT   = 3'd1,
      CLS_MULDIV    = 3'd2,
      CLS_I_ALU     = 3'd3,
      CLS_LOAD      = 3'd4,
      CLS_STORE     = 3'd5,
      CLS_BRANCH    = 3'd6,
      CLS_JUMP_LINK = 3'd7
   } exec_class_e;

   localparam logic [1:0] EXC_INVALID  = 2'd0;
   localparam logic [1:0] EXC_OVERFLOW = 2'd1;
   localparam logic [1:0] EXC_DIV_ZERO = 2'd2;

   localparam logic READ  = 1'b0;
   localparam logic WRITE = 1'b1;

   localparam logic [1:0] MEM_SEL_PC  = 2'b00;
   localparam logic [1:0] MEM_SEL_VEC = 2'b01;
   localparam logic [2:0] PC_SEL_ALU    = 3'b000;
   localparam logic [2:0] PC_SEL_ALUOUT = 3'b001;
   localparam logic [2:0] PC_SEL_JUMP   = 3'b010;
   localparam logic [2:0] PC_SEL_EPC    = 3'b011;
   localparam logic [2:0] PC_SEL_LSU    = 3'b100;
   localparam logic [1:0] SRCA_PC   = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] LS_BYTE_ZX = 2'b01;

endpackage

// File: rtl/multicycle_fetch_exc_sequencer_if.sv
// rtl/multicycle_fetch_exc_sequencer_if.sv - dispatch/completion handshake to the execute sequencers
interface multicycle_fetch_exc_sequencer_if #(
   parameter int unsigned N_EXC = 3
);
   logic             exec_start;
   logic [2:0]       exec_class;
   logic             exec_done;
   logic [N_EXC-2:0] exc_req;

   modport master (output exec_start, exec_class, input exec_done, exc_req);
   modport slave  (input exec_start, exec_class, output exec_done, exc_req);
endinterface

// File: rtl/multicycle_fetch_exc_sequencer_opcode_classifier.sv
// rtl/multicycle_fetch_exc_sequencer_opcode_classifier.sv - maps opcode/funct to an execute class
module opcode_classifier
   import mcpu_ctrl_pkg::*;
(
   input  logic [5:0]  opcode_i,
   input  logic [5:0]  funct_i,
   output exec_class_e class_o,
   output logic        is_j_o,
   output logic        is_rte_o,
   output logic        invalid_o
);

   always_comb begin
      class_o   = CLS_R_ALU;
      is_j_o    = 1'b0;
      is_rte_o  = 1'b0;
      invalid_o = 1'b0;
      case (opcode_i)
         OP_RTYPE: begin
            case (funct_i)
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:        class_o = CLS_R_ALU;
               FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRAV:     class_o = CLS_R_SHIFT;
               FN_MULT, FN_DIV, FN_MFHI, FN_MFLO:            class_o = CLS_MULDIV;
               FN_JR:                                        class_o = CLS_JUMP_LINK;
               FN_RTE:                                       is_rte_o = 1'b1;
               default:                                      invalid_o = 1'b1;
            endcase
         end
         OP_J:                               is_j_o  = 1'b1;
         OP_JAL:                             class_o = CLS_JUMP_LINK;
         OP_BEQ, OP_BNE, OP_BLE, OP_BGT:     class_o = CLS_BRANCH;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_LUI: class_o = CLS_I_ALU;
         OP_LB, OP_LH, OP_LW:                class_o = CLS_LOAD;
         OP_SB, OP_SH, OP_SW:                class_o = CLS_STORE;
         default:                            invalid_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_fetch_exc_sequencer.sv
// rtl/multicycle_fetch_exc_sequencer.sv - fetch/decode/dispatch control with precise exception entry
module multicycle_fetch_exc_sequencer
   import mcpu_ctrl_pkg::*;
#(
   parameter int unsigned MEM_LAT      = 1,
   parameter int unsigned CNT_W        = 3,
   parameter int unsigned N_EXC        = 3,
   parameter int unsigned EXC_VEC_BASE = 253
) (
   input  logic       clk,
   input  logic       reset_in,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   multicycle_fetch_exc_sequencer_if.master exec_bus,
   output logic       reset_out,
   output logic       PC_w,
   output logic       IR_w,
   output logic       MEM_w,
   output logic       EPC_w,
   output logic       ALUOut_w,
   output logic       MEM_DATA_REG_w,
   output logic [1:0] Mux_MEM,
   output logic [1:0] Mux_EXC,
   output logic [2:0] Mux_PC,
   output logic [1:0] Mux_ALUSrcA,
   output logic [1:0] Mux_ALUSrcB,
   output logic [3:0] ALUOp,
   output logic [1:0] LS_control,
   output logic [3:0] state_dbg
);

   if (MEM_LAT < 1 || MEM_LAT > (2 ** CNT_W) - 1) begin : g_bad_mem_lat
      $error("MEM_LAT does not fit the wait-state counter");
   end
   if (N_EXC < 2 || N_EXC > 4 || EXC_VEC_BASE + N_EXC - 1 > 255) begin : g_bad_vectors
      $error("exception vectors do not fit Mux_EXC or the byte address space");
   end

   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_LAT - 1);

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       exc_idx_q, exc_idx_d;
   exec_class_e      class_q, class_d;

   exec_class_e dec_class;
   logic        dec_is_j, dec_is_rte, dec_invalid;
   logic        wait_done;
   logic        exc_any;
   logic [1:0]  exc_pick;

   opcode_classifier u_classifier (
      .opcode_i  (opcode),
      .funct_i   (funct),
      .class_o   (dec_class),
      .is_j_o    (dec_is_j),
      .is_rte_o  (dec_is_rte),
      .invalid_o (dec_invalid)
   );

   assign wait_done = (cnt_q == LAST_WAIT);

   // exc_req bit k carries exception index k+1; scan downwards so the lowest set bit wins
   always_comb begin
      exc_any  = |exec_bus.exc_req;
      exc_pick = EXC_OVERFLOW;
      for (int i = int'(N_EXC) - 2; i >= 0; i--) begin
         if (exec_bus.exc_req[i]) exc_pick = 2'(i + 1);
      end
   end

   always_comb begin
      state_d   = state_q;
      exc_idx_d = exc_idx_q;
      class_d   = class_q;
      case (state_q)
         ST_RESET:    state_d = ST_FETCH;
         ST_FETCH:    state_d = ST_MEM_WAIT;
         ST_MEM_WAIT: if (wait_done) state_d = ST_DECODE;
         ST_DECODE:   state_d = ST_DISPATCH;
         ST_DISPATCH: begin
            if (dec_is_j || dec_is_rte) begin
               state_d = ST_FETCH;
            end else if (dec_invalid) begin
               state_d   = ST_EXC_EPC;
               exc_idx_d = EXC_INVALID;
            end else begin
               state_d = ST_EXEC;
               class_d = dec_class;
            end
         end
         ST_EXEC: begin
            if (exc_any) begin
               state_d   = ST_EXC_EPC;
               exc_idx_d = exc_pick;
            end else if (exec_bus.exec_done) begin
               state_d = ST_FETCH;
            end
         end
         ST_EXC_EPC:  state_d = ST_EXC_READ;
         ST_EXC_READ: if (wait_done) state_d = ST_EXC_LOAD;
         ST_EXC_LOAD: state_d = ST_EXC_JUMP;
         ST_EXC_JUMP: state_d = ST_FETCH;
         default:     state_d = ST_RESET;
      endcase
      if (state_d != state_q) cnt_d = '0;
      else if (wait_done)     cnt_d = cnt_q;
      else                    cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset_in) begin
         state_q   <= ST_RESET;
         cnt_q     <= '0;
         exc_idx_q <= '0;
         class_q   <= CLS_R_ALU;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         exc_idx_q <= exc_idx_d;
         class_q   <= class_d;
      end
   end

   // reset_in overrides combinationally so an abort never lets a write enable through
   always_comb begin
      reset_out           = reset_in;
      PC_w                = 1'b0;
      IR_w                = 1'b0;
      MEM_w               = READ;
      EPC_w               = 1'b0;
      ALUOut_w            = 1'b0;
      MEM_DATA_REG_w      = 1'b0;
      Mux_MEM             = MEM_SEL_PC;
      Mux_EXC             = '0;
      Mux_PC              = PC_SEL_ALU;
      Mux_ALUSrcA         = SRCA_PC;
      Mux_ALUSrcB         = '0;
      ALUOp               = ALU_NO_OP;
      LS_control          = '0;
      exec_bus.exec_start = 1'b0;
      exec_bus.exec_class = '0;
      if (!reset_in) begin
         case (state_q)
            ST_FETCH: begin
               Mux_ALUSrcB = SRCB_FOUR;
               ALUOp       = ALU_ADD;
               ALUOut_w    = 1'b1;
            end
            ST_DECODE: begin
               IR_w   = 1'b1;
               PC_w   = 1'b1;
               Mux_PC = PC_SEL_ALUOUT;
            end
            ST_DISPATCH: begin
               if (dec_is_j) begin
                  PC_w   = 1'b1;
                  Mux_PC = PC_SEL_JUMP;
               end else if (dec_is_rte) begin
                  PC_w   = 1'b1;
                  Mux_PC = PC_SEL_EPC;
               end else if (!dec_invalid) begin
                  exec_bus.exec_start = 1'b1;
                  exec_bus.exec_class = dec_class;
               end
            end
            ST_EXEC: exec_bus.exec_class = class_q;
            ST_EXC_EPC: begin
               Mux_ALUSrcB = SRCB_FOUR;
               ALUOp       = ALU_SUB;
               EPC_w       = 1'b1;
               Mux_EXC     = exc_idx_q;
            end
            ST_EXC_READ: begin
               Mux_MEM = MEM_SEL_VEC;
               Mux_EXC = exc_idx_q;
            end
            ST_EXC_LOAD: begin
               MEM_DATA_REG_w = 1'b1;
               Mux_EXC        = exc_idx_q;
            end
            ST_EXC_JUMP: begin
               LS_control = LS_BYTE_ZX;
               Mux_PC     = PC_SEL_LSU;
               PC_w       = 1'b1;
               Mux_EXC    = exc_idx_q;
            end
            default: ;
         endcase
      end
   end

   assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_fetch_exc_sequencer.sv
// tb/tb_multicycle_fetch_exc_sequencer.sv - randomized cycle-trace bench for MEM_LAT 1 and 3
module tb_multicycle_fetch_exc_sequencer;
   import mcpu_ctrl_pkg::*;

   typedef struct packed {
      logic       rst_o, pc_w, ir_w, mem_w, epc_w, aluout_w, mdr_w;
      logic [1:0] mmem, mexc;
      logic [2:0] mpc;
      logic [1:0] sa, sb;
      logic [3:0] aluop;
      logic [1:0] ls;
      logic       es;
      logic [2:0] ec;
   } ctl_t;

   typedef struct packed {
      logic       rst, done;
      logic [1:0] exr;
      logic [5:0] op, fn;
   } stim_t;

   // kind: 0 = dispatched to execute, 1 = J, 2 = RTE, 3 = invalid
   typedef struct packed {
      logic [5:0] op, fn;
      logic [1:0] kind;
      logic [2:0] cls;
   } ins_t;

   logic       clk = 1'b0;
   logic       rst  [2];
   logic       done [2];
   logic [1:0] exr  [2];
   logic [5:0] opc  [2];
   logic [5:0] fun  [2];
   ctl_t       obs  [2];
   logic [3:0] sdbg [2];

   int n_chk  = 0;
   int n_pass = 0;

   ctl_t  exp_q [$];
   stim_t stim_q[$];
   string tag_q [$];
   ins_t  tbl   [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      multicycle_fetch_exc_sequencer_if #(.N_EXC(3)) bus ();
      logic       rst_o, pc_w, ir_w, mem_w, epc_w, aluout_w, mdr_w;
      logic [1:0] mmem, mexc, sa, sb, ls;
      logic [2:0] mpc;
      logic [3:0] aluop, sd;

      multicycle_fetch_exc_sequencer #(
         .MEM_LAT(g == 0 ? 1 : 3), .CNT_W(3), .N_EXC(3), .EXC_VEC_BASE(253)
      ) dut (
         .clk(clk), .reset_in(rst[g]), .opcode(opc[g]), .funct(fun[g]), .exec_bus(bus),
         .reset_out(rst_o), .PC_w(pc_w), .IR_w(ir_w), .MEM_w(mem_w), .EPC_w(epc_w),
         .ALUOut_w(aluout_w), .MEM_DATA_REG_w(mdr_w), .Mux_MEM(mmem), .Mux_EXC(mexc),
         .Mux_PC(mpc), .Mux_ALUSrcA(sa), .Mux_ALUSrcB(sb), .ALUOp(aluop),
         .LS_control(ls), .state_dbg(sd)
      );

      assign bus.exec_done = done[g];
      assign bus.exc_req   = exr[g];
      assign obs[g]  = {rst_o, pc_w, ir_w, mem_w, epc_w, aluout_w, mdr_w, mmem, mexc, mpc,
                        sa, sb, aluop, ls, bus.exec_start, bus.exec_class};
      assign sdbg[g] = sd;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, want);
   endtask

   function automatic ins_t ins(logic [5:0] op, logic [5:0] fn, logic [1:0] kind, logic [2:0] cls);
      ins_t r;
      r.op = op; r.fn = fn; r.kind = kind; r.cls = cls;
      return r;
   endfunction

   function automatic stim_t st(logic r, logic dn, logic [1:0] x, logic [5:0] o, logic [5:0] f);
      stim_t s;
      s.rst = r; s.done = dn; s.exr = x; s.op = o; s.fn = f;
      return s;
   endfunction

   function automatic logic [1:0] junk();
      return 2'($urandom);
   endfunction

   function automatic ctl_t c_reset();
      ctl_t c = '0;
      c.rst_o = 1'b1;
      return c;
   endfunction

   task automatic push(input string tag, input ctl_t c, input stim_t s);
      tag_q.push_back(tag);
      exp_q.push_back(c);
      stim_q.push_back(s);
   endtask

   task automatic add_exc(input string nm, input int lat, input logic [1:0] idx, input int rst_at,
                          input logic [5:0] o, input logic [5:0] f);
      ctl_t c;
      c = '0; c.epc_w = 1'b1; c.sb = 2'b01; c.aluop = ALU_SUB; c.mexc = idx;
      push({nm, ".epc"}, c, st(0, 0, junk(), o, f));
      for (int i = 0; i < lat; i++) begin
         if (i == rst_at) begin
            push({nm, ".rst_mid"}, c_reset(), st(1, 0, junk(), o, f));
            push({nm, ".rst_hold"}, c_reset(), st(1, 0, junk(), o, f));
            push({nm, ".rst_release"}, '0, st(0, 0, junk(), o, f));
            return;
         end
         c = '0; c.mmem = 2'b01; c.mexc = idx;
         push({nm, ".vec_read"}, c, st(0, 0, junk(), o, f));
      end
      c = '0; c.mdr_w = 1'b1; c.mexc = idx;
      push({nm, ".vec_load"}, c, st(0, 0, junk(), o, f));
      c = '0; c.ls = 2'b01; c.mpc = 3'b100; c.pc_w = 1'b1; c.mexc = idx;
      push({nm, ".vec_jump"}, c, st(0, 0, junk(), o, f));
   endtask

   // One instruction from FETCH back to the next FETCH; waits = EXEC cycles before the finishing one
   task automatic add_instr(input string nm, input int lat, input ins_t in, input int waits,
                            input logic [1:0] exr_end, input int rst_at);
      ctl_t c;
      logic dn;
      c = '0; c.aluout_w = 1'b1; c.sb = 2'b01; c.aluop = ALU_ADD;
      push({nm, ".fetch"}, c, st(0, 0, junk(), in.op, in.fn));
      for (int i = 0; i < lat; i++) push({nm, ".mem_wait"}, '0, st(0, 0, junk(), in.op, in.fn));
      c = '0; c.ir_w = 1'b1; c.pc_w = 1'b1; c.mpc = 3'b001;
      push({nm, ".decode"}, c, st(0, 0, junk(), in.op, in.fn));
      c = '0;
      case (in.kind)
         2'd1: begin c.pc_w = 1'b1; c.mpc = 3'b010; push({nm, ".dispatch_j"}, c, st(0, 0, junk(), in.op, in.fn)); end
         2'd2: begin c.pc_w = 1'b1; c.mpc = 3'b011; push({nm, ".dispatch_rte"}, c, st(0, 0, junk(), in.op, in.fn)); end
         2'd3: begin
            push({nm, ".dispatch_inv"}, c, st(0, 0, junk(), in.op, in.fn));
            add_exc(nm, lat, 2'd0, rst_at, in.op, in.fn);
         end
         default: begin
            c.es = 1'b1; c.ec = in.cls;
            push({nm, ".dispatch"}, c, st(0, 0, junk(), in.op, in.fn));
            c = '0; c.ec = in.cls;
            for (int i = 0; i < waits; i++) push({nm, ".exec"}, c, st(0, 0, 2'b00, in.op, in.fn));
            dn = (exr_end == 2'b00) ? 1'b1 : 1'($urandom_range(0, 1));
            if (nm == "exc_and_done") dn = 1'b1;
            push({nm, ".exec_end"}, c, st(0, dn, exr_end, in.op, in.fn));
            if (exr_end != 2'b00)
               add_exc(nm, lat, exr_end[0] ? 2'd1 : 2'd2, rst_at, in.op, in.fn);
         end
      endcase
   endtask

   task automatic plan(input int lat);
      ins_t in;
      int   rat;
      logic [1:0] x;
      for (int i = 0; i < 3; i++) push($sformatf("reset%0d", i), c_reset(), st(1, 0, junk(), 0, 0));
      push("release", '0, st(0, 0, junk(), 0, 0));
      add_instr("add", lat, ins(6'h00, 6'h20, 2'd0, 3'd0), 2, 2'b00, -1);
      add_instr("jump", lat, ins(6'h02, 6'h15, 2'd1, 3'd0), 0, 2'b00, -1);
      add_instr("invalid", lat, ins(6'h3f, 6'h00, 2'd3, 3'd0), 0, 2'b00, -1);
      add_instr("exc_and_done", lat, ins(6'h00, 6'h22, 2'd0, 3'd0), 1, 2'b11, -1);
      add_instr("div_zero", lat, ins(6'h00, 6'h1a, 2'd0, 3'd2), 0, 2'b10, -1);
      add_instr("inv_reset", lat, ins(6'h3f, 6'h01, 2'd3, 3'd0), 0, 2'b00, lat - 1);
      add_instr("rte", lat, ins(6'h00, 6'h13, 2'd2, 3'd0), 0, 2'b00, -1);
      for (int k = 0; k < 30; k++) begin
         in = tbl[$urandom_range(0, tbl.size() - 1)];
         if (in.op != 6'h00) in.fn = 6'($urandom);
         x   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lat - 1)) : -1;
         add_instr($sformatf("rnd%0d", k), lat, in, int'($urandom_range(0, 4)), x, rat);
      end
   endtask

   task automatic run(input int d);
      stim_t s;
      ctl_t  e;
      string t;
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         @(posedge clk);
         #1;
         rst[d] = s.rst; done[d] = s.done; exr[d] = s.exr; opc[d] = s.op; fun[d] = s.fn;
         @(negedge clk);
         check($sformatf("dut%0d %s", d, t), 32'(obs[d]), 32'(e));
         if (t == "reset2") check($sformatf("dut%0d state_in_reset", d), 32'(sdbg[d]), 32'(ST_RESET));
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; done[d] = 1'b0; exr[d] = 2'b00; opc[d] = '0; fun[d] = '0;
      end
      tbl.push_back(ins(6'h00, 6'h20, 2'd0, 3'd0));
      tbl.push_back(ins(6'h00, 6'h2a, 2'd0, 3'd0));
      tbl.push_back(ins(6'h00, 6'h00, 2'd0, 3'd1));
      tbl.push_back(ins(6'h00, 6'h03, 2'd0, 3'd1));
      tbl.push_back(ins(6'h00, 6'h18, 2'd0, 3'd2));
      tbl.push_back(ins(6'h00, 6'h08, 2'd0, 3'd7));
      tbl.push_back(ins(6'h00, 6'h13, 2'd2, 3'd0));
      tbl.push_back(ins(6'h00, 6'h3f, 2'd3, 3'd0));
      tbl.push_back(ins(6'h08, 6'h00, 2'd0, 3'd3));
      tbl.push_back(ins(6'h0f, 6'h00, 2'd0, 3'd3));
      tbl.push_back(ins(6'h23, 6'h00, 2'd0, 3'd4));
      tbl.push_back(ins(6'h20, 6'h00, 2'd0, 3'd4));
      tbl.push_back(ins(6'h2b, 6'h00, 2'd0, 3'd5));
      tbl.push_back(ins(6'h28, 6'h00, 2'd0, 3'd5));
      tbl.push_back(ins(6'h04, 6'h00, 2'd0, 3'd6));
      tbl.push_back(ins(6'h05, 6'h00, 2'd0, 3'd6));
      tbl.push_back(ins(6'h03, 6'h00, 2'd0, 3'd7));
      tbl.push_back(ins(6'h02, 6'h00, 2'd1, 3'd0));
      tbl.push_back(ins(6'h3f, 6'h00, 2'd3, 3'd0));
      tbl.push_back(ins(6'h11, 6'h00, 2'd3, 3'd0));
      for (int d = 0; d < 2; d++) begin
         plan(d == 0 ? 1 : 3);
         run(d);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
